// File: rtl/xaui_rx_sync_ctrl.sv
// rtl/xaui_rx_sync_ctrl.sv - XAUI 4-lane receive sync state machines and transceiver reset watchdog
module xaui_rx_sync_ctrl #(
   parameter int COMMA_CNT = 4,
   parameter int GOOD_CNT  = 4,
   parameter int ERR_MAX   = 3,
   parameter int TIMEOUT   = 65536,
   parameter int RESET_LEN = 16
) (
   input  logic       mgt_clk,
   input  logic       mgt_reset,
   input  logic [7:0] rxcharisk,
   input  logic [7:0] rxcodecomma,
   input  logic [7:0] rxcodevalid,
   input  logic [3:0] rxlock,
   input  logic [3:0] rxbufferr,
   output logic [3:0] rxencommaalign,
   output logic [3:0] rxsyncok,
   output logic       link_up,
   output logic       gt_rx_reset,
   output logic [7:0] reset_count
);

   localparam logic [3:0]  COMMA_LIM = 4'(COMMA_CNT);
   localparam logic [3:0]  GOOD_LIM  = 4'(GOOD_CNT);
   localparam logic [2:0]  ERR_LIM   = 3'(ERR_MAX);
   localparam logic [23:0] TO_LIM    = 24'(TIMEOUT - 1);
   localparam logic [7:0]  RST_LIM   = 8'(RESET_LEN - 1);

   typedef enum logic [1:0] {LOS, CDET, SYNC} lane_state_t;
   typedef enum logic       {WD_MON, WD_RST} wd_state_t;

   wd_state_t   wd_state, wd_nxt;
   logic [23:0] down_cnt;
   logic [7:0]  rst_cnt;
   logic [3:0]  lock_hist;
   logic        wd_trigger;
   logic        gt_rx_reset_nxt;
   logic [3:0]  align_nxt;
   logic [3:0]  sync_nxt;

   // Watchdog trigger: timeout, buffer error or lock loss while the link is up
   always_comb begin
      wd_trigger = (wd_state == WD_MON) &&
                   ((!link_up && down_cnt == TO_LIM) ||
                    (|rxbufferr) ||
                    (link_up && |(lock_hist & ~rxlock)));
   end

   // Watchdog next state: a single trigger starts one pulse of RESET_LEN cycles
   always_comb begin
      wd_nxt = wd_state;
      case (wd_state)
         WD_MON:  if (wd_trigger) wd_nxt = WD_RST;
         WD_RST:  if (rst_cnt == RST_LIM) wd_nxt = WD_MON;
         default: wd_nxt = WD_MON;
      endcase
   end

   // Watchdog output decode from next state so the pulse is a plain flop
   always_comb begin
      gt_rx_reset_nxt = (wd_nxt == WD_RST);
   end

   // Watchdog state, counters, lock history and registered reset pulse
   always_ff @(posedge mgt_clk or posedge mgt_reset) begin
      if (mgt_reset) begin
         wd_state    <= WD_MON;
         down_cnt    <= '0;
         rst_cnt     <= '0;
         lock_hist   <= '0;
         reset_count <= '0;
         gt_rx_reset <= 1'b0;
      end else begin
         wd_state    <= wd_nxt;
         lock_hist   <= rxlock;
         gt_rx_reset <= gt_rx_reset_nxt;
         if (wd_state == WD_MON) begin
            if (wd_nxt == WD_RST) begin
               rst_cnt  <= '0;
               down_cnt <= '0;
               if (reset_count != 8'hFF) reset_count <= reset_count + 8'd1;
            end else if (link_up) begin
               down_cnt <= '0;
            end else begin
               down_cnt <= down_cnt + 24'd1;
            end
         end else begin
            rst_cnt  <= rst_cnt + 8'd1;
            down_cnt <= '0;
         end
      end
   end

   for (genvar l = 0; l < 4; l++) begin : g_lane
      lane_state_t st, st_nxt;
      logic [3:0]  cnt, cnt_nxt;
      logic [3:0]  good, good_nxt;
      logic [2:0]  errc, errc_nxt;
      logic        comma, err, force_los;

      assign comma     = |(rxcodecomma[2*l +: 2] & rxcharisk[2*l +: 2]);
      assign err       = ~&rxcodevalid[2*l +: 2];
      // Lanes follow the watchdog's next state so they sit in LOS exactly while the pulse is high
      assign force_los = !rxlock[l] || (wd_nxt == WD_RST);

      // Lane next state: comma acquisition, then error accounting with forgiveness
      always_comb begin
         st_nxt   = st;
         cnt_nxt  = cnt;
         good_nxt = good;
         errc_nxt = errc;
         if (force_los) begin
            st_nxt   = LOS;
            cnt_nxt  = '0;
            good_nxt = '0;
            errc_nxt = '0;
         end else begin
            case (st)
               LOS: begin
                  cnt_nxt  = '0;
                  good_nxt = '0;
                  errc_nxt = '0;
                  if (comma && !err) begin
                     cnt_nxt = 4'd1;
                     st_nxt  = (COMMA_LIM == 4'd1) ? SYNC : CDET;
                  end
               end
               CDET: begin
                  if (err) begin
                     st_nxt  = LOS;
                     cnt_nxt = '0;
                  end else if (comma) begin
                     if (cnt + 4'd1 == COMMA_LIM) begin
                        st_nxt   = SYNC;
                        errc_nxt = '0;
                        good_nxt = '0;
                     end
                     cnt_nxt = cnt + 4'd1;
                  end
               end
               SYNC: begin
                  if (err) begin
                     good_nxt = '0;
                     if (errc + 3'd1 == ERR_LIM) begin
                        st_nxt   = LOS;
                        errc_nxt = '0;
                        cnt_nxt  = '0;
                     end else begin
                        errc_nxt = errc + 3'd1;
                     end
                  end else if (errc != 3'd0) begin
                     if (good + 4'd1 == GOOD_LIM) begin
                        errc_nxt = errc - 3'd1;
                        good_nxt = '0;
                     end else begin
                        good_nxt = good + 4'd1;
                     end
                  end else if (good != GOOD_LIM) begin
                     good_nxt = good + 4'd1;
                  end
               end
               default: st_nxt = LOS;
            endcase
         end
      end

      // Lane output decode from next state, registered below
      assign align_nxt[l] = (st_nxt != SYNC);
      assign sync_nxt[l]  = (st_nxt == SYNC);

      // Lane state and counter register
      always_ff @(posedge mgt_clk or posedge mgt_reset) begin
         if (mgt_reset) begin
            st   <= LOS;
            cnt  <= '0;
            good <= '0;
            errc <= '0;
         end else begin
            st   <= st_nxt;
            cnt  <= cnt_nxt;
            good <= good_nxt;
            errc <= errc_nxt;
         end
      end
   end

   // Registered lane status and port link indication
   always_ff @(posedge mgt_clk or posedge mgt_reset) begin
      if (mgt_reset) begin
         rxencommaalign <= 4'hF;
         rxsyncok       <= 4'h0;
         link_up        <= 1'b0;
      end else begin
         rxencommaalign <= align_nxt;
         rxsyncok       <= sync_nxt;
         link_up        <= &sync_nxt;
      end
   end

endmodule

// File: tb/tb_xaui_rx_sync_ctrl.sv
// tb/tb_xaui_rx_sync_ctrl.sv - directed self-checking bench for xaui_rx_sync_ctrl
module tb_xaui_rx_sync_ctrl;
   localparam int TO = 40;
   localparam int RL = 16;

   logic       mgt_clk = 1'b0;
   logic       mgt_reset;
   logic [7:0] rxcharisk, rxcodecomma, rxcodevalid;
   logic [3:0] rxlock, rxbufferr;
   logic [3:0] rxencommaalign, rxsyncok;
   logic       link_up, gt_rx_reset;
   logic [7:0] reset_count;

   int checks = 0;
   int errors = 0;

   xaui_rx_sync_ctrl #(.COMMA_CNT(4), .GOOD_CNT(4), .ERR_MAX(3), .TIMEOUT(TO), .RESET_LEN(RL)) dut (
      .mgt_clk(mgt_clk), .mgt_reset(mgt_reset),
      .rxcharisk(rxcharisk), .rxcodecomma(rxcodecomma), .rxcodevalid(rxcodevalid),
      .rxlock(rxlock), .rxbufferr(rxbufferr),
      .rxencommaalign(rxencommaalign), .rxsyncok(rxsyncok), .link_up(link_up),
      .gt_rx_reset(gt_rx_reset), .reset_count(reset_count)
   );

   always #5 mgt_clk = ~mgt_clk;

   task automatic tick();
      @(posedge mgt_clk);
      #1;
   endtask

   // c: lanes carrying a comma (even lanes on byte 0, odd lanes on byte 1); e: lanes with a code error
   task automatic set_lanes(input logic [3:0] c, input logic [3:0] e);
      rxcharisk   = '0;
      rxcodecomma = '0;
      for (int l = 0; l < 4; l++) begin
         rxcharisk[2*l + (l % 2)]   = c[l];
         rxcodecomma[2*l + (l % 2)] = c[l];
         rxcodevalid[2*l +: 2]      = e[l] ? 2'b10 : 2'b11;
      end
   endtask

   task automatic do_reset();
      mgt_reset = 1'b1;
      rxbufferr = 4'h0;
      rxlock    = 4'hF;
      set_lanes(4'h0, 4'h0);
      tick();
      tick();
      mgt_reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (rxencommaalign !== 4'hF) begin errors++; $display("FAIL reset_align: got %h expected f", rxencommaalign); end
      checks++; if (rxsyncok !== 4'h0) begin errors++; $display("FAIL reset_syncok: got %h expected 0", rxsyncok); end
      checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link_up: got %b expected 0", link_up); end
      checks++; if (gt_rx_reset !== 1'b0) begin errors++; $display("FAIL reset_gt: got %b expected 0", gt_rx_reset); end
      checks++; if (reset_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", reset_count); end
   endtask

   task automatic test_timeout();
      int hi, w, guard;
      do_reset();
      hi = 0;
      repeat (TO - 1) begin tick(); if (gt_rx_reset) hi++; end
      checks++; if (hi !== 0) begin errors++; $display("FAIL timeout_early: got %0d high cycles expected 0", hi); end
      checks++; if (rxencommaalign !== 4'hF || rxsyncok !== 4'h0) begin errors++; $display("FAIL timeout_lanes: got align %h sync %h expected f 0", rxencommaalign, rxsyncok); end
      tick();
      checks++; if (gt_rx_reset !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b expected 1", gt_rx_reset); end
      checks++; if (reset_count !== 8'd1) begin errors++; $display("FAIL timeout_count: got %0d expected 1", reset_count); end
      w = 0; guard = 0;
      while (gt_rx_reset === 1'b1 && guard < 64) begin w++; tick(); guard++; end
      checks++; if (w !== RL) begin errors++; $display("FAIL timeout_width: got %0d expected %0d", w, RL); end
   endtask

   task automatic test_sync();
      do_reset();
      set_lanes(4'hF, 4'h0);
      repeat (3) tick();
      checks++; if (rxsyncok !== 4'h0) begin errors++; $display("FAIL sync_early: got %h expected 0", rxsyncok); end
      tick();
      checks++; if (rxsyncok !== 4'hF || link_up !== 1'b1 || rxencommaalign !== 4'h0) begin errors++; $display("FAIL sync_all: got sync %h link %b align %h expected f 1 0", rxsyncok, link_up, rxencommaalign); end

      do_reset();
      set_lanes(4'hF, 4'h0);
      repeat (3) tick();
      set_lanes(4'hF, 4'b0100);
      tick();
      checks++; if (rxsyncok !== 4'b1011 || rxencommaalign !== 4'b0100 || link_up !== 1'b0) begin errors++; $display("FAIL sync_lane2_err: got sync %h align %h link %b expected b 4 0", rxsyncok, rxencommaalign, link_up); end
      set_lanes(4'hF, 4'h0);
      repeat (3) tick();
      checks++; if (rxsyncok !== 4'b1011) begin errors++; $display("FAIL sync_lane2_early: got %h expected b", rxsyncok); end
      tick();
      checks++; if (rxsyncok !== 4'hF || link_up !== 1'b1) begin errors++; $display("FAIL sync_lane2_resync: got sync %h link %b expected f 1", rxsyncok, link_up); end
   endtask

   task automatic test_err_accum();
      do_reset();
      set_lanes(4'hF, 4'h0);
      repeat (4) tick();
      for (int c = 0; c < 5; c++) begin
         set_lanes(4'h0, (c % 2 == 0) ? 4'b0010 : 4'b0000);
         tick();
         if (c == 3) begin
            checks++; if (rxsyncok !== 4'hF) begin errors++; $display("FAIL err_two_outstanding: got %h expected f", rxsyncok); end
         end
      end
      checks++; if (rxsyncok !== 4'b1101 || rxencommaalign !== 4'b0010 || link_up !== 1'b0) begin errors++; $display("FAIL err_third_drop: got sync %h align %h link %b expected d 2 0", rxsyncok, rxencommaalign, link_up); end

      do_reset();
      set_lanes(4'hF, 4'h0);
      repeat (4) tick();
      for (int c = 0; c < 16; c++) begin
         set_lanes(4'h0, (c % 5 == 0) ? 4'b0010 : 4'b0000);
         tick();
      end
      checks++; if (rxsyncok !== 4'hF || link_up !== 1'b1) begin errors++; $display("FAIL err_forgiven: got sync %h link %b expected f 1", rxsyncok, link_up); end
   endtask

   task automatic test_bufferr();
      int w, bad, guard;
      do_reset();
      set_lanes(4'hF, 4'h0);
      repeat (4) tick();
      checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL buf_link_up: got %b expected 1", link_up); end
      rxbufferr = 4'b1000;
      tick();
      rxbufferr = 4'h0;
      checks++; if (gt_rx_reset !== 1'b1 || reset_count !== 8'd1) begin errors++; $display("FAIL buf_pulse: got gt %b count %0d expected 1 1", gt_rx_reset, reset_count); end
      checks++; if (rxsyncok !== 4'h0 || rxencommaalign !== 4'hF || link_up !== 1'b0) begin errors++; $display("FAIL buf_lanes_los: got sync %h align %h link %b expected 0 f 0", rxsyncok, rxencommaalign, link_up); end
      w = 0; bad = 0; guard = 0;
      while (gt_rx_reset === 1'b1 && guard < 64) begin
         w++;
         if (rxsyncok !== 4'h0) bad++;
         tick();
         guard++;
      end
      checks++; if (w !== RL) begin errors++; $display("FAIL buf_width: got %0d expected %0d", w, RL); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL buf_hold_los: got %0d synced cycles expected 0", bad); end
   endtask

   task automatic test_simultaneous();
      int w, guard;
      do_reset();
      set_lanes(4'h0, 4'h0);
      repeat (TO - 1) tick();
      rxbufferr = 4'h1;
      tick();
      rxbufferr = 4'h0;
      checks++; if (gt_rx_reset !== 1'b1 || reset_count !== 8'd1) begin errors++; $display("FAIL simul_pulse: got gt %b count %0d expected 1 1", gt_rx_reset, reset_count); end
      w = 0; guard = 0;
      while (gt_rx_reset === 1'b1 && guard < 64) begin
         w++;
         rxbufferr = (w == 5) ? 4'h4 : 4'h0;
         tick();
         guard++;
      end
      rxbufferr = 4'h0;
      checks++; if (w !== RL) begin errors++; $display("FAIL simul_width: got %0d expected %0d", w, RL); end
      repeat (5) tick();
      checks++; if (gt_rx_reset !== 1'b0 || reset_count !== 8'd1) begin errors++; $display("FAIL simul_single: got gt %b count %0d expected 0 1", gt_rx_reset, reset_count); end
   endtask

   task automatic test_lock_loss();
      do_reset();
      set_lanes(4'hF, 4'h0);
      repeat (4) tick();
      rxlock = 4'b1110;
      tick();
      checks++; if (rxsyncok !== 4'h0 || gt_rx_reset !== 1'b1 || reset_count !== 8'd1) begin errors++; $display("FAIL lock_loss: got sync %h gt %b count %0d expected 0 1 1", rxsyncok, gt_rx_reset, reset_count); end
      rxlock = 4'hF;
   endtask

   task automatic test_saturate();
      int rises, guard;
      logic prev;
      do_reset();
      set_lanes(4'h0, 4'h0);
      rises = 0; guard = 0; prev = 1'b0;
      while (rises < 300 && guard < 300 * (TO + RL) + 200) begin
         tick();
         if (gt_rx_reset && !prev) rises++;
         prev = gt_rx_reset;
         guard++;
      end
      checks++; if (rises !== 300) begin errors++; $display("FAIL sat_rises: got %0d expected 300", rises); end
      checks++; if (reset_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d expected 255", reset_count); end
      repeat (3) tick();
      checks++; if (gt_rx_reset !== 1'b1) begin errors++; $display("FAIL sat_mid_pulse: got %b expected 1", gt_rx_reset); end
      mgt_reset = 1'b1;
      #1;
      checks++; if (gt_rx_reset !== 1'b0 || reset_count !== 8'd0) begin errors++; $display("FAIL async_reset_wd: got gt %b count %0d expected 0 0", gt_rx_reset, reset_count); end
      checks++; if (rxencommaalign !== 4'hF || rxsyncok !== 4'h0 || link_up !== 1'b0) begin errors++; $display("FAIL async_reset_lanes: got align %h sync %h link %b expected f 0 0", rxencommaalign, rxsyncok, link_up); end
      tick();
      mgt_reset = 1'b0;
   endtask

   initial begin
      mgt_reset = 1'b1;
      rxbufferr = 4'h0;
      rxlock    = 4'hF;
      set_lanes(4'h0, 4'h0);
      test_reset();
      test_timeout();
      test_sync();
      test_err_accum();
      test_bufferr();
      test_simultaneous();
      test_lock_loss();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/xaui_rx_sync_ctrl.md
# xaui_rx_sync_ctrl

Per-port receive synchronisation controller for the 4-lane XAUI receive path. It sits downstream of the per-lane steering stage and upstream of the XAUI core. For each lane it runs a comma/code-error sync state machine that drives comma alignment enable and per-lane sync status. It also runs a port-level watchdog that pulses the transceiver receive reset after loss of lock, a buffer error, or a prolonged link-down.

## Interface
Parameters:
- COMMA_CNT, 4: consecutive comma-bearing, error-free cycles needed to declare lane sync (1..15).
- GOOD_CNT, 4: consecutive error-free cycles that forgive one accumulated error (1..15).
- ERR_MAX, 3: accumulated errors that drop lane sync (1..7).
- TIMEOUT, 65536: link-down cycles before the watchdog resets the transceiver (1..2^24-1).
- RESET_LEN, 16: width of the gt_rx_reset pulse in cycles (1..255).

Ports:
- mgt_clk  in  1  receive-side clock; all logic on rising edge.
- mgt_reset  in  1  asynchronous, active-high reset.
- rxcharisk  in  8  K-flag, 2 bits per lane, lane L at [2L+1:2L].
- rxcodecomma  in  8  comma flag, same packing.
- rxcodevalid  in  8  code-valid flag, same packing.
- rxlock  in  4  per-lane CDR lock.
- rxbufferr  in  4  per-lane elastic buffer error.
- rxencommaalign  out  4  per-lane comma alignment enable.
- rxsyncok  out  4  per-lane sync acquired.
- link_up  out  1  all four lanes synced.
- gt_rx_reset  out  1  transceiver receive reset pulse.
- reset_count  out  8  watchdog resets issued, saturating at 255.

## Operation
Per-cycle lane qualifiers:
- comma(L): for either byte b, rxcodecomma[2L+b] and rxcharisk[2L+b] are both 1.
- err(L): either rxcodevalid bit of lane L is 0.

Lane FSM, one per lane, 3 states:
- LOS: rxencommaalign=1, rxsyncok=0, counters cleared. comma(L) && !err(L) -> CDET with cnt=1.
- CDET: rxencommaalign=1, rxsyncok=0.
  - err(L) -> LOS.
  - Cycle with comma(L) increments cnt; cnt reaching COMMA_CNT -> SYNC with err_cnt=0, good_cnt=0.
  - Non-comma, error-free cycles hold cnt.
- SYNC: rxencommaalign=0, rxsyncok=1.
  - err(L) increments err_cnt and clears good_cnt. err_cnt reaching ERR_MAX -> LOS.
  - Error-free cycle increments good_cnt. When good_cnt reaches GOOD_CNT and err_cnt>0: decrement err_cnt and clear good_cnt. good_cnt saturates when err_cnt=0.
- Any state: rxlock[L]=0 or watchdog in RST -> LOS. This has priority over all other transitions.

link_up is the AND of the four rxsyncok bits.

Watchdog FSM, 2 states:
- MON: down_cnt increments each cycle while link_up=0 and clears while link_up=1.
  - Go to RST when any of the following holds: down_cnt reaches TIMEOUT-1 on a link-down cycle, any rxbufferr bit is 1, or any rxlock bit falls (1->0, one-cycle registered history) while link_up=1.
  - On entering RST: rst_cnt=0 and reset_count increments, saturating.
- RST: gt_rx_reset=1 for exactly RESET_LEN cycles, then -> MON with down_cnt=0. rxbufferr, rxlock and timeout are ignored while in RST.
- Simultaneous triggers in the same cycle produce one reset and one count increment.

## Timing
- All outputs are registered. State is updated on the edge that samples the qualifying inputs, and outputs reflect the new state after that edge (1-cycle latency from input to output).
- Lane sync: the first comma is sampled at edge 0, and rxsyncok=1 after edge COMMA_CNT-1 when commas occur on consecutive cycles.
- Lane loss: rxsyncok=0 after the edge sampling the ERR_MAX-th outstanding error.
- link_up updates on the same edge as the rxsyncok that completes the AND.
- Watchdog: gt_rx_reset rises on the edge after the trigger is sampled and stays high for RESET_LEN edges. While it is high, all lanes are held in LOS.
- Reset values (asynchronous): all lanes LOS, rxencommaalign=4'hF, rxsyncok=0, link_up=0, gt_rx_reset=0, reset_count=0, watchdog in MON with down_cnt=0, rxlock history=0.
- mgt_reset asserted mid-pulse ends the pulse immediately.
- Counter widths: down_cnt is 24 bits, reset_count is 8 bits. Lane counters are 4 bits for cnt and good_cnt, and 3 bits for err_cnt.

## Test plan
- Reset, then rxlock=4'hF and valid non-comma data -> rxencommaalign=4'hF, rxsyncok=0, and after TIMEOUT cycles one 16-cycle gt_rx_reset pulse with reset_count=1.
- Commas on all lanes for 4 consecutive error-free cycles -> rxsyncok=4'hF, link_up=1 and rxencommaalign=0 after the 4th edge. An error during cycle 3 on lane 2 restarts lane 2 only.
- Synced lane 1 with invalid codes on cycles 0, 2 and 4, all other cycles good -> lane 1 drops to LOS after cycle 4. Repeat with 4 good cycles between errors -> lane 1 stays SYNC.
- rxbufferr[3] pulsed while link is up -> gt_rx_reset high for RESET_LEN cycles, all lanes go to LOS, reset_count increments by 1.
- Timeout expiry and rxbufferr in the same cycle -> exactly one pulse and reset_count +1. A second rxbufferr during the pulse is ignored.
- 300 forced timeouts -> reset_count saturates at 255. Assert mgt_reset mid-pulse -> all outputs return to reset values immediately.
